msrv32_dmem_if: RTL and testbench
=================================

MSRV32_DMEM_IF -- requirements
Module: msrv32_dmem_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of wait-state cycles in the data phase before the transfer is aborted (legal range 2..255).
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid_in, input, 1 bit: the pipeline requests a data access.
REQ-005 SHALL have port req_ready_out, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have ports req_write_in (input, 1 bit), req_addr_in (input, 32 bits), req_wdata_in (input, 32 bits), req_size_in (input, 2 bits: 00 byte, 01 half, 10 word) and req_unsigned_in (input, 1 bit).
REQ-007 SHALL have AHB-Lite master outputs haddr_out (32), htrans_out (2), hwrite_out (1), hsize_out (3) and hwdata_out (32).
REQ-008 SHALL have AHB-Lite master inputs hrdata_in (32), hready_in (1) and hresp_in (1).
REQ-009 SHALL have load-unit-facing outputs data_out (32), iadder_1_to_0_out (2), load_size_out (2), load_unsigned_out (1) and ahb_resp_out (1: 1 means error or timeout).
REQ-010 SHALL have outputs done_out (1: one-cycle completion pulse) and misaligned_out (1).

Function
REQ-011 SHALL implement the FSM states IDLE, ADDR and DATA.
REQ-012 SHALL assert req_ready_out only in IDLE; a request is accepted when req_valid_in and req_ready_out are both 1 on a clock edge.
REQ-013 On acceptance, SHALL register req_addr_in, req_wdata_in, req_size_in, req_unsigned_in and req_write_in, then go to ADDR.
REQ-014 In ADDR, SHALL drive htrans_out=2'b10 (NONSEQ), haddr_out=captured address, hwrite_out=captured write flag and hsize_out={1'b0,captured size}.
REQ-015 In ADDR, SHALL go to DATA only when hready_in=1; while hready_in=0 it SHALL hold all address-phase outputs stable.
REQ-016 Outside ADDR, SHALL drive htrans_out=2'b00 (IDLE).
REQ-017 In DATA, SHALL drive hwdata_out=captured write data.
REQ-018 In DATA, when hready_in=1, SHALL register hrdata_in into data_out and hresp_in into ahb_resp_out, pulse done_out for one cycle, and return to IDLE.
REQ-019 In DATA, SHALL count consecutive cycles with hready_in=0.
REQ-020 When that count reaches TIMEOUT_CYCLES, SHALL set ahb_resp_out=1, pulse done_out, leave data_out unchanged and return to IDLE.
REQ-021 SHALL reset the wait counter on every entry to DATA.
REQ-022 If hready_in=1 in the same cycle the count reaches its limit, the normal completion of REQ-018 SHALL take priority over the timeout.
REQ-023 SHALL hold iadder_1_to_0_out, load_size_out and load_unsigned_out at the captured request values from acceptance until the next acceptance.
REQ-024 SHALL hold data_out and ahb_resp_out until the next completion.
REQ-025 For a write, SHALL leave data_out unchanged on completion and still pulse done_out.
REQ-026 Latency with zero wait states SHALL be: accept at edge N, ADDR during cycle N+1, DATA during cycle N+2, done_out high in cycle N+3.
REQ-027 SHALL never issue back-to-back transfers; at least one IDLE cycle SHALL separate successive transfers.

Reset
REQ-028 When ms_riscv32_mp_rst_in=0 at a clock edge, SHALL go to IDLE regardless of current state, including mid-transfer, and drop any in-flight transaction without a done_out pulse.
REQ-029 Reset values SHALL be: htrans_out=00; haddr_out, hwdata_out and data_out=0; hwrite_out, done_out, ahb_resp_out and misaligned_out=0; hsize_out=000; iadder_1_to_0_out and load_size_out=00; load_unsigned_out=0; wait counter=0.
REQ-030 req_ready_out SHALL be 1 from the first cycle after reset is released.

Configuration
REQ-031 The macro MSRV32_DMEM_MISALIGN_CHECK_EN SHALL compile the misalignment check in or out.
REQ-032 With the macro defined, an accepted request with half size and addr[0]=1, or word size and addr[1:0]!=00, SHALL skip ADDR and DATA, drive no bus transfer, and in the next cycle pulse done_out with misaligned_out=1 and ahb_resp_out=1.
REQ-033 Without the macro, misaligned_out SHALL be tied to 0 and all requests SHALL be issued on the bus unchanged.

Verification
REQ-034 Zero-wait word load to 0x100 with hrdata=0xDEADBEEF -> done_out in cycle N+3, data_out=0xDEADBEEF, ahb_resp_out=0, iadder_1_to_0_out=00.
REQ-035 Byte load to 0x103 with 3 wait states -> haddr_out=0x103 and hsize_out=000 held stable; done_out 3 cycles later than the zero-wait case; iadder_1_to_0_out=11.
REQ-036 Word store with hready_in held at 0 and TIMEOUT_CYCLES=16 -> done_out after 16 DATA wait cycles, ahb_resp_out=1, data_out unchanged.
REQ-037 hresp_in=1 together with hready_in=1 in DATA -> ahb_resp_out=1, done_out pulse.
REQ-038 Reset driven low during DATA -> next cycle in IDLE, htrans_out=00, no done_out pulse, req_ready_out=1 after reset is released.
REQ-039 With MSRV32_DMEM_MISALIGN_CHECK_EN defined, a half-word load to 0x101 -> htrans_out stays 00, misaligned_out=1 and done_out=1 in cycle N+1.

Source files
------------

// File: rtl/msrv32_dmem_if_if.sv
// AHB-Lite master-side bus bundle for the msrv32 data-memory interface.
interface msrv32_dmem_if_if;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  modport master (
    output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
    input  hrdata_in, hready_in, hresp_in
  );

  modport slave (
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
    output hrdata_in, hready_in, hresp_in
  );
endinterface

// File: rtl/msrv32_dmem_if.sv
// Single-outstanding AHB-Lite data-memory master with data-phase timeout.
// Optional misalignment trap enabled by `define MSRV32_DMEM_MISALIGN_CHECK_EN.
module msrv32_dmem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic             req_write_in,
  input  logic [31:0]      req_addr_in,
  input  logic [31:0]      req_wdata_in,
  input  logic [1:0]       req_size_in,
  input  logic             req_unsigned_in,
  msrv32_dmem_if_if.master ahb,
  output logic [31:0]      data_out,
  output logic [1:0]       iadder_1_to_0_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic             ahb_resp_out,
  output logic             done_out,
  output logic             misaligned_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] data_q, data_d;
  logic        resp_q, resp_d;
  logic        done_q, done_d;
  logic        misalign;

`ifdef MSRV32_DMEM_MISALIGN_CHECK_EN
  logic mis_q;

  assign misalign = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                    ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));

  // A completion raised from IDLE can only be a trapped misaligned request.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      mis_q <= 1'b0;
    end else if (done_d) begin
      mis_q <= (state_q == IDLE);
    end
  end

  assign misaligned_out = mis_q;
`else
  assign misalign       = 1'b0;
  assign misaligned_out = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    write_d       = write_q;
    wait_d        = wait_q;
    data_d        = data_q;
    resp_d        = resp_q;
    done_d        = 1'b0;
    req_ready_out = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          addr_d  = req_addr_in;
          wdata_d = req_wdata_in;
          size_d  = req_size_in;
          uns_d   = req_unsigned_in;
          write_d = req_write_in;
          if (misalign) begin
            done_d = 1'b1;
            resp_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (ahb.hready_in) begin
          state_d = DATA;
          wait_d  = '0;
        end
      end
      DATA: begin
        // Ready completion is tested first so it wins over a coincident timeout.
        if (ahb.hready_in) begin
          done_d  = 1'b1;
          resp_d  = ahb.hresp_in;
          state_d = IDLE;
          if (!write_q) begin
            data_d = ahb.hrdata_in;
          end
        end else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b1;
          resp_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wait_q  <= '0;
      data_q  <= '0;
      resp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
    end
  end

  assign ahb.haddr_out  = addr_q;
  assign ahb.htrans_out = (state_q == ADDR) ? 2'b10 : 2'b00;
  assign ahb.hwrite_out = write_q;
  assign ahb.hsize_out  = {1'b0, size_q};
  assign ahb.hwdata_out = wdata_q;

  assign data_out          = data_q;
  assign iadder_1_to_0_out = addr_q[1:0];
  assign load_size_out     = size_q;
  assign load_unsigned_out = uns_q;
  assign ahb_resp_out      = resp_q;
  assign done_out          = done_q;

endmodule

// File: tb/tb_msrv32_dmem_if.sv
// Bench for msrv32_dmem_if: directed cases plus randomized transfers against a transaction-level model.
module tb_msrv32_dmem_if;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_out;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] data_out;
  logic [1:0]  iadder_1_to_0_out;
  logic [1:0]  load_size_out;
  logic        load_unsigned_out;
  logic        ahb_resp_out;
  logic        done_out;
  logic        misaligned_out;

  msrv32_dmem_if_if bus ();

  msrv32_dmem_if #(.TIMEOUT_CYCLES(T)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .req_valid_in         (req_valid),
    .req_ready_out        (req_ready_out),
    .req_write_in         (req_write),
    .req_addr_in          (req_addr),
    .req_wdata_in         (req_wdata),
    .req_size_in          (req_size),
    .req_unsigned_in      (req_unsigned),
    .ahb                  (bus.master),
    .data_out             (data_out),
    .iadder_1_to_0_out    (iadder_1_to_0_out),
    .load_size_out        (load_size_out),
    .load_unsigned_out    (load_unsigned_out),
    .ahb_resp_out         (ahb_resp_out),
    .done_out             (done_out),
    .misaligned_out       (misaligned_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data;
  logic        exp_resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer: aw address-phase waits, dw data-phase waits (dw >= T means the slave never answers).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int unsigned aw,
                         input int unsigned dw, input logic [31:0] rdata, input logic rresp);
    logic        mis;
    logic        last;
    bit          to;
    int unsigned nd;
    mis = 1'b0;
`ifdef MSRV32_DMEM_MISALIGN_CHECK_EN
    mis = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
`endif
    check("ready_idle", 32'(req_ready_out), 32'd1);
    req_valid     = 1'b1;
    req_write     = wr;
    req_addr      = addr;
    req_wdata     = wdata;
    req_size      = size;
    req_unsigned  = uns;
    bus.hready_in = 1'b1;
    step();
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    if (mis) begin
      check("mis_done", 32'(done_out), 32'd1);
      check("mis_flag", 32'(misaligned_out), 32'd1);
      check("mis_htrans", 32'(bus.htrans_out), 32'd0);
      exp_resp = 1'b1;
    end else begin
      for (int unsigned i = 0; i <= aw; i++) begin
        check("addr_htrans", 32'(bus.htrans_out), 32'd2);
        check("addr_haddr", bus.haddr_out, addr);
        check("addr_hwrite", 32'(bus.hwrite_out), 32'(wr));
        check("addr_hsize", 32'(bus.hsize_out), 32'(size));
        check("addr_nodone", 32'(done_out), 32'd0);
        bus.hready_in = (i == aw);
        bus.hrdata_in = $urandom;
        bus.hresp_in  = 1'($urandom);
        step();
      end
      to = (dw >= T);
      nd = to ? T : dw + 1;
      for (int unsigned i = 0; i < nd; i++) begin
        check("data_htrans", 32'(bus.htrans_out), 32'd0);
        check("data_hwdata", bus.hwdata_out, wdata);
        check("data_nodone", 32'(done_out), 32'd0);
        check("data_noready", 32'(req_ready_out), 32'd0);
        last          = !to && (i == dw);
        bus.hready_in = last;
        bus.hrdata_in = last ? rdata : $urandom;
        bus.hresp_in  = last ? rresp : 1'($urandom);
        step();
      end
      check("done", 32'(done_out), 32'd1);
      check("mis_clear", 32'(misaligned_out), 32'd0);
      if (!wr && !to) exp_data = rdata;
      exp_resp = to ? 1'b1 : rresp;
    end
    check("cmp_data", data_out, exp_data);
    check("cmp_resp", 32'(ahb_resp_out), 32'(exp_resp));
    check("cmp_iadder", 32'(iadder_1_to_0_out), 32'(addr[1:0]));
    check("cmp_lsize", 32'(load_size_out), 32'(size));
    check("cmp_luns", 32'(load_unsigned_out), 32'(uns));
    check("cmp_ready", 32'(req_ready_out), 32'd1);
    check("cmp_htrans", 32'(bus.htrans_out), 32'd0);
    bus.hready_in = 1'b1;
    step();
    check("post_nodone", 32'(done_out), 32'd0);
    check("post_data", data_out, exp_data);
    check("post_resp", 32'(ahb_resp_out), 32'(exp_resp));
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_size      = '0;
    req_unsigned  = 1'b0;
    bus.hrdata_in = '0;
    bus.hready_in = 1'b1;
    bus.hresp_in  = 1'b0;
    exp_data      = '0;
    exp_resp      = 1'b0;

    step();
    step();
    check("rst_htrans", 32'(bus.htrans_out), 32'd0);
    check("rst_haddr", bus.haddr_out, 32'd0);
    check("rst_hwdata", bus.hwdata_out, 32'd0);
    check("rst_hwrite", 32'(bus.hwrite_out), 32'd0);
    check("rst_hsize", 32'(bus.hsize_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_resp", 32'(ahb_resp_out), 32'd0);
    check("rst_mis", 32'(misaligned_out), 32'd0);
    check("rst_iadder", 32'(iadder_1_to_0_out), 32'd0);
    check("rst_lsize", 32'(load_size_out), 32'd0);
    check("rst_luns", 32'(load_unsigned_out), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_ready", 32'(req_ready_out), 32'd1);

    // zero-wait word load
    run_txn(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    // byte load with 3 data-phase waits
    run_txn(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 0, 3, 32'h1234_5678, 1'b0);
    // address-phase waits on a half load
    run_txn(1'b0, 32'h0000_0202, 32'h0, 2'b01, 1'b0, 3, 1, 32'hCAFE_F00D, 1'b0);
    // store that times out
    run_txn(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 2'b10, 1'b0, 0, T, 32'h0, 1'b0);
    // ready on the final allowed wait cycle completes normally
    run_txn(1'b0, 32'h0000_0300, 32'h0, 2'b10, 1'b0, 0, T - 1, 32'h0BAD_CAFE, 1'b0);
    // load timeout leaves data untouched
    run_txn(1'b0, 32'h0000_0304, 32'h0, 2'b10, 1'b0, 1, T + 3, 32'hFFFF_FFFF, 1'b0);
    // error response
    run_txn(1'b0, 32'h0000_0400, 32'h0, 2'b10, 1'b0, 0, 0, 32'h7777_8888, 1'b1);
    // store completes, data held
    run_txn(1'b1, 32'h0000_0404, 32'h1111_2222, 2'b10, 1'b0, 0, 2, 32'h9999_9999, 1'b0);
    // half load to 0x101: trapped when the check is built in, issued on the bus otherwise
    run_txn(1'b0, 32'h0000_0101, 32'h0, 2'b01, 1'b0, 0, 0, 32'h4444_5555, 1'b0);
    run_txn(1'b0, 32'h0000_0106, 32'h0, 2'b10, 1'b0, 1, 1, 32'h6666_1111, 1'b0);

    // reset in the middle of the data phase
    check("mid_ready", 32'(req_ready_out), 32'd1);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h0000_0500;
    req_size     = 2'b10;
    bus.hready_in = 1'b1;
    step();
    req_valid = 1'b0;
    check("mid_addr", 32'(bus.htrans_out), 32'd2);
    step();
    check("mid_data_nodone", 32'(done_out), 32'd0);
    bus.hready_in = 1'b0;
    rst_n         = 1'b0;
    step();
    check("mid_htrans", 32'(bus.htrans_out), 32'd0);
    check("mid_nodone", 32'(done_out), 32'd0);
    check("mid_data", data_out, 32'd0);
    check("mid_resp", 32'(ahb_resp_out), 32'd0);
    exp_data      = '0;
    exp_resp      = 1'b0;
    rst_n         = 1'b1;
    bus.hready_in = 1'b1;
    step();
    check("mid_ready_rel", 32'(req_ready_out), 32'd1);
    check("mid_nodone_rel", 32'(done_out), 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic        wr;
      logic [1:0]  sz;
      int unsigned aw;
      int unsigned dw;
      wr = 1'($urandom);
      sz = 2'($urandom_range(0, 2));
      aw = $urandom_range(0, 3);
      dw = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 4);
      run_txn(wr, $urandom, $urandom, sz, 1'($urandom), aw, dw, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
